// File: rtl/fifo_frame_packer_pkg.sv
// fifo_pkg: shared constants and types for the FIFO frame packer slice.
//   FIFO_WIDTH     - default data word width, matches the synchronous FIFO
//   packer_state_e - packer FSM state encoding {IDLE, LOAD, SEND, CSUM}
package fifo_pkg;

  localparam int FIFO_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    CSUM = 2'd3
  } packer_state_e;

endpackage

// File: rtl/fifo_frame_packer_if.sv
// fifo_frame_packer_if: groups the FIFO read-side signals and the outgoing
// frame stream of the packer.
//   fifo_empty, fifo_data_out, fifo_rd_en - FIFO read port (data_out valid
//                                           the cycle after rd_en)
//   m_data, m_valid, m_last, m_ready      - outgoing word stream
// Stream handshake: a word transfers on a rising edge where m_valid and
// m_ready are both 1. Once m_valid is raised, m_data/m_valid/m_last hold
// steady until that transfer; m_ready may be low for any number of cycles
// and may be high before or in the same cycle that m_valid rises.
// Modports: master = packer side, slave = FIFO model / stream consumer side.
interface fifo_frame_packer_if import fifo_pkg::*; #(
  parameter int WIDTH = FIFO_WIDTH
) ();

  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data_out;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_last;
  logic             m_ready;

  modport master (
    input  fifo_empty,
    input  fifo_data_out,
    input  m_ready,
    output fifo_rd_en,
    output m_data,
    output m_valid,
    output m_last
  );

  modport slave (
    output fifo_empty,
    output fifo_data_out,
    output m_ready,
    input  fifo_rd_en,
    input  m_data,
    input  m_valid,
    input  m_last
  );

endinterface

// File: rtl/fifo_frame_packer_csum_acc.sv
// frame_csum_acc: WIDTH-bit modular accumulator for the frame checksum.
//   clk, rst  - clock and synchronous active-high reset
//   add_en    - add add_data into the running sum this cycle
//   clr       - zero the sum (wins over add_en)
//   add_data  - word to accumulate
//   sum       - running sum, carry out of the top bit is dropped
module frame_csum_acc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             add_en,
  input  logic             clr,
  input  logic [WIDTH-1:0] add_data,
  output logic [WIDTH-1:0] sum
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + add_data;
    end
  end

endmodule

// File: rtl/fifo_frame_packer.sv
// fifo_frame_packer: pops words from the FIFO read port, forwards them as
// frames of FRAME_LEN words on a valid/ready stream and closes each frame
// with a checksum word flagged by m_last. Sole driver of the FIFO rd_en.
//   clk, rst   - clock and synchronous active-high reset
//   bus        - master side of fifo_frame_packer_if (FIFO read + stream)
//   frame_cnt  - number of completed frames, wraps 255 -> 0
//   state_dbg  - current FSM state for observation
module fifo_frame_packer import fifo_pkg::*; #(
  parameter int FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
  parameter int FRAME_LEN  = 4
) (
  input  logic                clk,
  input  logic                rst,
  fifo_frame_packer_if.master bus,
  output logic [7:0]          frame_cnt,
  output packer_state_e       state_dbg
);

  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  packer_state_e         state_q;
  packer_state_e         state_d;
  logic [FIFO_WIDTH-1:0] data_q;
  logic [FIFO_WIDTH-1:0] csum;
  logic [7:0]            word_cnt_q;
  logic                  load_word;
  logic                  data_accept;
  logic                  csum_accept;

  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stream outputs are decoded from registered state only, so they cannot
  // change while a word is waiting for m_ready. Reads are issued only from
  // IDLE, which keeps at most one popped word in flight.
  always_comb begin
    state_d         = state_q;
    bus.fifo_rd_en  = 1'b0;
    bus.m_valid     = 1'b0;
    bus.m_last      = 1'b0;
    bus.m_data      = '0;
    load_word       = 1'b0;
    data_accept     = 1'b0;
    csum_accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.fifo_empty && !rst) begin
          bus.fifo_rd_en = 1'b1;
          state_d        = LOAD;
        end
      end
      LOAD: begin
        load_word = 1'b1;
        state_d   = SEND;
      end
      SEND: begin
        bus.m_valid = 1'b1;
        bus.m_data  = data_q;
        if (bus.m_ready) begin
          data_accept = 1'b1;
          state_d     = (word_cnt_q == LAST_IDX) ? CSUM : IDLE;
        end
      end
      CSUM: begin
        bus.m_valid = 1'b1;
        bus.m_last  = 1'b1;
        bus.m_data  = csum;
        if (bus.m_ready) begin
          csum_accept = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      word_cnt_q <= '0;
      frame_cnt  <= '0;
    end else begin
      if (load_word) begin
        data_q <= bus.fifo_data_out;
      end
      if (csum_accept) begin
        word_cnt_q <= '0;
        frame_cnt  <= frame_cnt + 8'd1;
      end else if (data_accept) begin
        word_cnt_q <= word_cnt_q + 8'd1;
      end
    end
  end

  frame_csum_acc #(
    .WIDTH(FIFO_WIDTH)
  ) u_csum (
    .clk      (clk),
    .rst      (rst),
    .add_en   (load_word),
    .clr      (csum_accept),
    .add_data (bus.fifo_data_out),
    .sum      (csum)
  );

endmodule

// File: tb/tb_fifo_frame_packer.sv
// tb_fifo_frame_packer: directed bench for fifo_frame_packer with a
// behavioural FIFO read port, a stream monitor and an expected-beat queue.
module tb_fifo_frame_packer;
  import fifo_pkg::*;

  localparam int W  = FIFO_WIDTH;
  localparam int FL = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    frame_cnt;
  packer_state_e state_dbg;

  always #5 clk = ~clk;

  fifo_frame_packer_if #(.WIDTH(W)) bus ();

  fifo_frame_packer #(
    .FIFO_WIDTH (W),
    .FRAME_LEN  (FL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .frame_cnt (frame_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- FIFO read-port model ----------------
  logic [W-1:0] fifo_mem [0:4095];
  logic [11:0]  wr_ptr = 12'd0;
  logic [11:0]  rd_ptr = 12'd0;
  int           underflow_cnt = 0;

  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      if (wr_ptr == rd_ptr) begin
        underflow_cnt <= underflow_cnt + 1;
      end else begin
        bus.fifo_data_out <= fifo_mem[rd_ptr];
        rd_ptr            <= rd_ptr + 12'd1;
      end
    end
  end

  // ---------------- stream monitor ----------------
  logic [W-1:0] obs_data [0:2047];
  logic         obs_last [0:2047];
  int           obs_wr    = 0;
  int           rd_pulses = 0;

  always @(negedge clk) begin
    if (!rst && bus.m_valid && bus.m_ready) begin
      obs_data[obs_wr] = bus.m_data;
      obs_last[obs_wr] = bus.m_last;
      obs_wr           = obs_wr + 1;
    end
    if (bus.fifo_rd_en) rd_pulses = rd_pulses + 1;
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q [$];
  bit           exp_last_q [$];
  int           obs_rd    = 0;
  int           tests_run = 0;
  int           fail_cnt  = 0;

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [W-1:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr           = wr_ptr + 12'd1;
  endtask

  task automatic expect_beat(input logic [W-1:0] w, input bit last);
    exp_q.push_back(w);
    exp_last_q.push_back(last);
  endtask

  task automatic push_frame(input logic [W-1:0] w0, input logic [W-1:0] w1,
                            input logic [W-1:0] w2, input logic [W-1:0] w3,
                            input logic [W-1:0] csum);
    push_word(w0); push_word(w1); push_word(w2); push_word(w3);
    expect_beat(w0, 1'b0); expect_beat(w1, 1'b0);
    expect_beat(w2, 1'b0); expect_beat(w3, 1'b0);
    expect_beat(csum, 1'b1);
  endtask

  task automatic wait_beats(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if (obs_wr - obs_rd >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if (bus.m_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    tests_run++;
    if (bus.m_valid !== 1'b0 || bus.m_last !== 1'b0 || bus.m_data !== 16'h0000) begin
      fail_cnt++;
      $display("FAIL reset_stream: valid=%b last=%b data=%h, want 0 0 0000",
               bus.m_valid, bus.m_last, bus.m_data);
    end
    tests_run++;
    if (frame_cnt !== 8'd0 || state_dbg !== IDLE || bus.fifo_rd_en !== 1'b0) begin
      fail_cnt++;
      $display("FAIL reset_ctrl: frame_cnt=%0d state=%0d rd_en=%b, want 0 IDLE 0",
               frame_cnt, state_dbg, bus.fifo_rd_en);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    tests_run++;
    if (bus.fifo_rd_en !== 1'b0) begin
      fail_cnt++;
      $display("FAIL idle_empty_rd: rd_en=%b, want 0", bus.fifo_rd_en);
    end
  endtask

  task automatic test_basic_frame();
    int base;
    bit ok;
    base = rd_pulses;
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    push_frame(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h000A);
    @(negedge clk); #1;
    tests_run++;
    if (bus.fifo_rd_en !== 1'b1) begin
      fail_cnt++;
      $display("FAIL latency_rd_en: rd_en=%b, want 1", bus.fifo_rd_en);
    end
    @(negedge clk); #1;
    tests_run++;
    if (bus.m_valid !== 1'b0 || state_dbg !== LOAD) begin
      fail_cnt++;
      $display("FAIL latency_load: valid=%b state=%0d, want 0 LOAD", bus.m_valid, state_dbg);
    end
    @(negedge clk); #1;
    tests_run++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 16'h0001) begin
      fail_cnt++;
      $display("FAIL latency_valid: valid=%b data=%h, want 1 0001", bus.m_valid, bus.m_data);
    end
    wait_beats(5, 100, ok);
    tests_run++;
    if (!ok) begin
      fail_cnt++;
      $display("FAIL basic_timeout: beats=%0d, want 5", obs_wr - obs_rd);
      obs_rd = obs_wr; exp_q.delete(); exp_last_q.delete();
    end
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      bit el;
      e  = exp_q.pop_front();
      el = exp_last_q.pop_front();
      tests_run++;
      if (obs_data[obs_rd] !== e || obs_last[obs_rd] !== el) begin
        fail_cnt++;
        $display("FAIL basic_beat%0d: got %h last=%b, want %h last=%b",
                 obs_rd, obs_data[obs_rd], obs_last[obs_rd], e, el);
      end
      obs_rd++;
    end
    @(posedge clk); #1;
    tests_run++;
    if (frame_cnt !== 8'd1 || rd_pulses - base !== 4) begin
      fail_cnt++;
      $display("FAIL basic_counts: frame_cnt=%0d rd_pulses=%0d, want 1 4",
               frame_cnt, rd_pulses - base);
    end
  endtask

  task automatic test_csum_wrap();
    bit ok;
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    push_frame(16'hFFFF, 16'h0002, 16'h0000, 16'h0000, 16'h0001);
    wait_beats(5, 100, ok);
    tests_run++;
    if (!ok) begin
      fail_cnt++;
      $display("FAIL wrap_timeout: beats=%0d, want 5", obs_wr - obs_rd);
      obs_rd = obs_wr; exp_q.delete(); exp_last_q.delete();
    end
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      bit el;
      e  = exp_q.pop_front();
      el = exp_last_q.pop_front();
      tests_run++;
      if (obs_data[obs_rd] !== e || obs_last[obs_rd] !== el) begin
        fail_cnt++;
        $display("FAIL wrap_beat%0d: got %h last=%b, want %h last=%b",
                 obs_rd, obs_data[obs_rd], obs_last[obs_rd], e, el);
      end
      obs_rd++;
    end
    @(posedge clk); #1;
    tests_run++;
    if (frame_cnt !== 8'd2) begin
      fail_cnt++;
      $display("FAIL wrap_frame_cnt: got %0d, want 2", frame_cnt);
    end
  endtask

  task automatic test_backpressure();
    int base;
    bit ok;
    base = rd_pulses;
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    push_frame(16'h0B01, 16'h0B02, 16'h0B03, 16'h0B04, 16'h2C0A);
    wait_beats(1, 50, ok);
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    wait_valid(20, ok);
    tests_run++;
    if (!ok || bus.m_data !== 16'h0B02) begin
      fail_cnt++;
      $display("FAIL bp_word2: valid_seen=%b data=%h, want 1 0b02", ok, bus.m_data);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      tests_run++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== 16'h0B02 || bus.m_last !== 1'b0 ||
          bus.fifo_rd_en !== 1'b0) begin
        fail_cnt++;
        $display("FAIL bp_stall%0d: valid=%b data=%h last=%b rd_en=%b, want 1 0b02 0 0",
                 c, bus.m_valid, bus.m_data, bus.m_last, bus.fifo_rd_en);
      end
    end
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    wait_beats(5, 100, ok);
    tests_run++;
    if (!ok) begin
      fail_cnt++;
      $display("FAIL bp_timeout: beats=%0d, want 5", obs_wr - obs_rd);
      obs_rd = obs_wr; exp_q.delete(); exp_last_q.delete();
    end
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      bit el;
      e  = exp_q.pop_front();
      el = exp_last_q.pop_front();
      tests_run++;
      if (obs_data[obs_rd] !== e || obs_last[obs_rd] !== el) begin
        fail_cnt++;
        $display("FAIL bp_beat%0d: got %h last=%b, want %h last=%b",
                 obs_rd, obs_data[obs_rd], obs_last[obs_rd], e, el);
      end
      obs_rd++;
    end
    @(posedge clk); #1;
    tests_run++;
    if (frame_cnt !== 8'd3 || rd_pulses - base !== 4 || underflow_cnt !== 0) begin
      fail_cnt++;
      $display("FAIL bp_counts: frame_cnt=%0d rd_pulses=%0d underflow=%0d, want 3 4 0",
               frame_cnt, rd_pulses - base, underflow_cnt);
    end
  endtask

  task automatic test_starvation();
    int viol;
    bit ok;
    viol = 0;
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    push_word(16'h0010); expect_beat(16'h0010, 1'b0);
    push_word(16'h0020); expect_beat(16'h0020, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (bus.fifo_empty && bus.fifo_rd_en) viol++;
    end
    tests_run++;
    if (viol !== 0) begin
      fail_cnt++;
      $display("FAIL starve_rd_en: %0d reads while empty, want 0", viol);
    end
    tests_run++;
    if (obs_wr - obs_rd !== 2 || state_dbg !== IDLE || frame_cnt !== 8'd3) begin
      fail_cnt++;
      $display("FAIL starve_wait: beats=%0d state=%0d frame_cnt=%0d, want 2 IDLE 3",
               obs_wr - obs_rd, state_dbg, frame_cnt);
    end
    @(posedge clk); #1;
    push_word(16'h0030); expect_beat(16'h0030, 1'b0);
    push_word(16'h0040); expect_beat(16'h0040, 1'b0);
    expect_beat(16'h00A0, 1'b1);
    wait_beats(5, 100, ok);
    tests_run++;
    if (!ok) begin
      fail_cnt++;
      $display("FAIL starve_timeout: beats=%0d, want 5", obs_wr - obs_rd);
      obs_rd = obs_wr; exp_q.delete(); exp_last_q.delete();
    end
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      bit el;
      e  = exp_q.pop_front();
      el = exp_last_q.pop_front();
      tests_run++;
      if (obs_data[obs_rd] !== e || obs_last[obs_rd] !== el) begin
        fail_cnt++;
        $display("FAIL starve_beat%0d: got %h last=%b, want %h last=%b",
                 obs_rd, obs_data[obs_rd], obs_last[obs_rd], e, el);
      end
      obs_rd++;
    end
    @(posedge clk); #1;
    tests_run++;
    if (frame_cnt !== 8'd4) begin
      fail_cnt++;
      $display("FAIL starve_frame_cnt: got %0d, want 4", frame_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    push_word(16'h0100); expect_beat(16'h0100, 1'b0);
    push_word(16'h0200); expect_beat(16'h0200, 1'b0);
    push_word(16'h0300);
    wait_beats(2, 50, ok);
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    wait_valid(20, ok);
    tests_run++;
    if (!ok || bus.m_data !== 16'h0300) begin
      fail_cnt++;
      $display("FAIL mid_pending: valid_seen=%b data=%h, want 1 0300", ok, bus.m_data);
    end
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      bit el;
      e  = exp_q.pop_front();
      el = exp_last_q.pop_front();
      tests_run++;
      if (obs_data[obs_rd] !== e || obs_last[obs_rd] !== el) begin
        fail_cnt++;
        $display("FAIL mid_pre_beat%0d: got %h last=%b, want %h last=%b",
                 obs_rd, obs_data[obs_rd], obs_last[obs_rd], e, el);
      end
      obs_rd++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    push_word(16'h1000); push_word(16'h2000); push_word(16'h3000); push_word(16'h4000);
    @(posedge clk);
    @(negedge clk); #1;
    tests_run++;
    if (bus.m_valid !== 1'b0 || bus.m_last !== 1'b0 || bus.m_data !== 16'h0000 ||
        frame_cnt !== 8'd0 || state_dbg !== IDLE) begin
      fail_cnt++;
      $display("FAIL mid_reset_out: valid=%b last=%b data=%h frame_cnt=%0d state=%0d, want 0 0 0000 0 IDLE",
               bus.m_valid, bus.m_last, bus.m_data, frame_cnt, state_dbg);
    end
    tests_run++;
    if (bus.fifo_rd_en !== 1'b0) begin
      fail_cnt++;
      $display("FAIL mid_reset_rd_en: rd_en=%b with data queued, want 0", bus.fifo_rd_en);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.m_ready = 1'b1;
    expect_beat(16'h1000, 1'b0); expect_beat(16'h2000, 1'b0);
    expect_beat(16'h3000, 1'b0); expect_beat(16'h4000, 1'b0);
    expect_beat(16'hA000, 1'b1);
    wait_beats(5, 100, ok);
    tests_run++;
    if (!ok) begin
      fail_cnt++;
      $display("FAIL mid_timeout: beats=%0d, want 5", obs_wr - obs_rd);
      obs_rd = obs_wr; exp_q.delete(); exp_last_q.delete();
    end
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      bit el;
      e  = exp_q.pop_front();
      el = exp_last_q.pop_front();
      tests_run++;
      if (obs_data[obs_rd] !== e || obs_last[obs_rd] !== el) begin
        fail_cnt++;
        $display("FAIL mid_post_beat%0d: got %h last=%b, want %h last=%b",
                 obs_rd, obs_data[obs_rd], obs_last[obs_rd], e, el);
      end
      obs_rd++;
    end
    @(posedge clk); #1;
    tests_run++;
    if (frame_cnt !== 8'd1) begin
      fail_cnt++;
      $display("FAIL mid_frame_cnt: got %0d, want 1", frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    bit ok;
    logic [W-1:0] w [4];
    logic [W-1:0] s;
    base = rd_pulses;
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    for (int f = 0; f < 256; f++) begin
      s = '0;
      for (int i = 0; i < 4; i++) begin
        w[i] = 16'(f * 257 + i * 16'h1111 + 16'hF000);
        s    = s + w[i];
      end
      push_frame(w[0], w[1], w[2], w[3], s);
      if (f == 254) begin
        wait_beats(255 * 5, 255 * 13 + 100, ok);
        tests_run++;
        if (!ok) begin
          fail_cnt++;
          $display("FAIL b2b_timeout: beats=%0d, want %0d", obs_wr - obs_rd, 255 * 5);
        end
        @(posedge clk); #1;
        tests_run++;
        if (frame_cnt !== 8'd0) begin
          fail_cnt++;
          $display("FAIL b2b_wrap: frame_cnt=%0d, want 0", frame_cnt);
        end
      end
    end
    wait_beats(exp_q.size(), 200, ok);
    tests_run++;
    if (!ok) begin
      fail_cnt++;
      $display("FAIL b2b_tail_timeout: beats=%0d, want %0d", obs_wr - obs_rd, exp_q.size());
      obs_rd = obs_wr; exp_q.delete(); exp_last_q.delete();
    end
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      bit el;
      e  = exp_q.pop_front();
      el = exp_last_q.pop_front();
      tests_run++;
      if (obs_data[obs_rd] !== e || obs_last[obs_rd] !== el) begin
        fail_cnt++;
        $display("FAIL b2b_beat%0d: got %h last=%b, want %h last=%b",
                 obs_rd, obs_data[obs_rd], obs_last[obs_rd], e, el);
      end
      obs_rd++;
    end
    @(posedge clk); #1;
    tests_run++;
    if (frame_cnt !== 8'd1 || rd_pulses - base !== 1024 || underflow_cnt !== 0) begin
      fail_cnt++;
      $display("FAIL b2b_counts: frame_cnt=%0d rd_pulses=%0d underflow=%0d, want 1 1024 0",
               frame_cnt, rd_pulses - base, underflow_cnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.m_ready = 1'b0;
    test_reset();
    test_basic_frame();
    test_csum_wrap();
    test_backpressure();
    test_starvation();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
